dma_bus_arbiter: RTL and testbench

Arbitrates the single data-memory port between the CPU data side (D-cache line fills and write-backs) and the DMA controller's BR/BG bus handshake. It sits between the cpu/DMA pair and Memory's data port. It grants the bus to the DMA only at a transaction boundary, stalls the CPU while the DMA owns the bus, and keeps grant and stall performance counters.

---
 rtl/dma_bus_arbiter.sv | 174 +++++++++++++++++
 tb/tb_dma_bus_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_bus_arbiter.sv
// Arbiter for the data-memory port between CPU line traffic and the DMA BR/BG handshake.
// Optional DMA hold limit: define ARB_STEAL_LIMIT_EN (uses MAX_GRANT).
module dma_bus_arbiter #(
  parameter int WORD_SIZE  = 16,
  parameter int LINE_WORDS = 4,
  parameter int MAX_GRANT  = 12
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            cpu_readM,
  input  logic                            cpu_writeM,
  input  logic [WORD_SIZE-1:0]            cpu_address,
  input  logic [WORD_SIZE*LINE_WORDS-1:0] cpu_wdata,
  output logic [WORD_SIZE*LINE_WORDS-1:0] cpu_rdata,
  output logic                            cpu_readyM,
  output logic                            cpu_doneM,
  output logic                            cpu_stall,
  input  logic                            dma_br,
  output logic                            dma_bg,
  input  logic                            dma_writeM,
  input  logic [WORD_SIZE-1:0]            dma_address,
  input  logic [WORD_SIZE*LINE_WORDS-1:0] dma_wdata,
  output logic                            dma_doneM,
  output logic                            mem_readM,
  output logic                            mem_writeM,
  output logic [WORD_SIZE-1:0]            mem_address,
  output logic [WORD_SIZE*LINE_WORDS-1:0] mem_wdata,
  input  logic [WORD_SIZE*LINE_WORDS-1:0] mem_rdata,
  input  logic                            mem_readyM,
  input  logic                            mem_doneM,
  output logic [WORD_SIZE-1:0]            num_dma_grant,
  output logic [WORD_SIZE-1:0]            num_cpu_stall,
  output logic [2:0]                      dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CPU_BUSY = 3'd1,
    S_DRAIN    = 3'd2,
    S_DMA      = 3'd3,
    S_RELEASE  = 3'd4
  } state_t;

  state_t state_q, state_d;
  logic dma_bg_q, dma_bg_d;
  logic [WORD_SIZE-1:0] grant_cnt_q, grant_cnt_d, stall_cnt_q, stall_cnt_d;
  logic cpu_req, cpu_cmpl, cpu_own, dma_inflight, grant, revoke, grant_ok;

  // Handshake: dma_br is a level request; dma_bg is a registered level grant.
  // The DMA may only drive dma_writeM while dma_bg=1 and holds it until dma_doneM.
  assign cpu_req      = cpu_readM | cpu_writeM;
  assign cpu_cmpl     = (cpu_readM & mem_readyM) | (cpu_writeM & mem_doneM);
  assign cpu_own      = (state_q == S_IDLE) | (state_q == S_CPU_BUSY) | (state_q == S_DRAIN);
  assign dma_inflight = (state_q == S_DMA) & dma_writeM & ~mem_doneM;
  assign grant        = (state_d == S_DMA) & (state_q != S_DMA);

`ifdef ARB_STEAL_LIMIT_EN
  localparam int HW = $clog2(MAX_GRANT + 1) + 1;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d, hold_inc;
  logic block_q, block_d;

  // hold_inc counts DMA cycles including the current one, saturating at the limit.
  assign hold_inc = (hold_cnt_q >= HW'(MAX_GRANT)) ? hold_cnt_q : hold_cnt_q + HW'(1);
  assign revoke   = (state_q == S_DMA) & (hold_inc >= HW'(MAX_GRANT)) & cpu_req & ~dma_inflight;
  assign grant_ok = ~block_q;

  always_comb begin
    hold_cnt_d = hold_cnt_q;
    block_d    = block_q;
    if (grant) hold_cnt_d = '0;
    else if (state_q == S_DMA) hold_cnt_d = hold_inc;
    if (revoke) block_d = 1'b1;
    else if (cpu_own && cpu_cmpl) block_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hold_cnt_q <= '0;
      block_q    <= 1'b0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
      block_q    <= block_d;
    end
  end
`else
  logic unused_max_grant;
  assign unused_max_grant = (MAX_GRANT > 0);
  assign revoke   = 1'b0;
  assign grant_ok = 1'b1;
`endif

  // A CPU request seen in IDLE already reaches Memory, so it wins a tie with dma_br.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (cpu_req) begin
          if (cpu_cmpl) state_d = dma_br ? S_DMA : S_IDLE;
          else          state_d = dma_br ? S_DRAIN : S_CPU_BUSY;
        end else if (dma_br && grant_ok) begin
          state_d = S_DMA;
        end
      end
      S_CPU_BUSY: begin
        if (cpu_cmpl)    state_d = dma_br ? S_DMA : S_IDLE;
        else if (dma_br) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (cpu_cmpl)     state_d = dma_br ? S_DMA : S_IDLE;
        else if (!dma_br) state_d = S_CPU_BUSY;
      end
      S_DMA: begin
        if ((!dma_br && !dma_inflight) || revoke) state_d = S_RELEASE;
      end
      S_RELEASE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    dma_bg_d    = (state_d == S_DMA);
    grant_cnt_d = grant_cnt_q + WORD_SIZE'(grant);
    stall_cnt_d = stall_cnt_q + WORD_SIZE'(cpu_stall & cpu_req);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      dma_bg_q    <= 1'b0;
      grant_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      dma_bg_q    <= dma_bg_d;
      grant_cnt_q <= grant_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_comb begin
    mem_readM   = 1'b0;
    mem_writeM  = 1'b0;
    mem_address = cpu_address;
    mem_wdata   = cpu_wdata;
    case (state_q)
      S_IDLE, S_CPU_BUSY, S_DRAIN: begin
        mem_readM  = cpu_readM;
        mem_writeM = cpu_writeM;
      end
      S_DMA: begin
        mem_writeM  = dma_writeM;
        mem_address = dma_address;
        mem_wdata   = dma_wdata;
      end
      default: ;
    endcase
    // An interrupted transaction must not keep strobing Memory during reset.
    if (!reset_n) begin
      mem_readM  = 1'b0;
      mem_writeM = 1'b0;
    end
  end

  assign cpu_stall     = (state_q == S_DMA) | (state_q == S_RELEASE);
  assign cpu_rdata     = mem_rdata;
  assign cpu_readyM    = mem_readyM & cpu_own;
  assign cpu_doneM     = mem_doneM & cpu_own;
  assign dma_doneM     = mem_doneM & (state_q == S_DMA);
  assign dma_bg        = dma_bg_q;
  assign num_dma_grant = grant_cnt_q;
  assign num_cpu_stall = stall_cnt_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Directed bench for dma_bus_arbiter with read-data and DMA-write scoreboards.
module tb_dma_bus_arbiter;
  localparam int WS = 16;
  localparam int LW = 64;
  localparam logic [2:0] ST_IDLE = 3'd0, ST_BUSY = 3'd1, ST_DRAIN = 3'd2,
                         ST_DMA = 3'd3, ST_REL = 3'd4;

  logic clk = 1'b0;
  logic reset_n;
  logic cpu_readM, cpu_writeM, cpu_readyM, cpu_doneM, cpu_stall;
  logic [WS-1:0] cpu_address, dma_address, mem_address, num_dma_grant, num_cpu_stall;
  logic [LW-1:0] cpu_wdata, cpu_rdata, dma_wdata, mem_wdata, mem_rdata;
  logic dma_br, dma_bg, dma_writeM, dma_doneM;
  logic mem_readM, mem_writeM, mem_readyM, mem_doneM;
  logic [2:0] dbg_state;

  int n_checks = 0;
  int n_fail = 0;
  int exp_stall;
  logic [LW-1:0] rd_exp_q[$];
  logic [LW-1:0] wr_exp_q[$];
  logic [LW-1:0] wa_exp_q[$];

  dma_bus_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_readM(cpu_readM), .cpu_writeM(cpu_writeM), .cpu_address(cpu_address),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_readyM(cpu_readyM),
    .cpu_doneM(cpu_doneM), .cpu_stall(cpu_stall),
    .dma_br(dma_br), .dma_bg(dma_bg), .dma_writeM(dma_writeM),
    .dma_address(dma_address), .dma_wdata(dma_wdata), .dma_doneM(dma_doneM),
    .mem_readM(mem_readM), .mem_writeM(mem_writeM), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_readyM(mem_readyM),
    .mem_doneM(mem_doneM), .num_dma_grant(num_dma_grant),
    .num_cpu_stall(num_cpu_stall), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    cpu_readM = 0; cpu_writeM = 0; cpu_address = '0; cpu_wdata = '0;
    dma_br = 0; dma_writeM = 0; dma_address = '0; dma_wdata = '0;
    mem_rdata = '0; mem_readyM = 0; mem_doneM = 0;
  endtask

  task automatic do_reset();
    reset_n = 0;
    clear_inputs();
    cyc();
    cyc();
    reset_n = 1;
  endtask

  task automatic mem_read_ready();
    logic [LW-1:0] d;
    d = {$urandom, $urandom};
    mem_rdata = d;
    mem_readyM = 1;
    rd_exp_q.push_back(d);
  endtask

  task automatic dma_write_start(input bit expect_done);
    dma_address = WS'($urandom_range(0, 16'hffff));
    dma_wdata = {$urandom, $urandom};
    dma_writeM = 1;
    if (expect_done) begin
      wr_exp_q.push_back(dma_wdata);
      wa_exp_q.push_back(LW'(dma_address));
    end
  endtask

  // Completion monitor: pops expectations when the DUT reports a finished transfer.
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (cpu_readyM) begin
        check_eq("rd_sb_avail", LW'(rd_exp_q.size() != 0), LW'(1));
        if (rd_exp_q.size() != 0) check_eq("cpu_rdata", cpu_rdata, rd_exp_q.pop_front());
      end
      if (dma_doneM) begin
        check_eq("wr_sb_avail", LW'(wr_exp_q.size() != 0), LW'(1));
        if (wr_exp_q.size() != 0) begin
          check_eq("dma_wdata", mem_wdata, wr_exp_q.pop_front());
          check_eq("dma_waddr", LW'(mem_address), wa_exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    reset_n = 0;
    clear_inputs();
    cpu_readM = 1;
    settle();
    check_eq("rst_mem_read_forced", LW'(mem_readM), LW'(0));
    cyc();
    check_eq("rst_bg", LW'(dma_bg), LW'(0));
    check_eq("rst_stall", LW'(cpu_stall), LW'(0));
    check_eq("rst_state", LW'(dbg_state), LW'(ST_IDLE));
    check_eq("rst_grant_cnt", LW'(num_dma_grant), LW'(0));
    check_eq("rst_stall_cnt", LW'(num_cpu_stall), LW'(0));

    // Idle grant with one DMA write, then release.
    do_reset();
    cyc();
    dma_br = 1;
    settle();
    check_eq("t1_bg_not_comb", LW'(dma_bg), LW'(0));
    cyc();
    check_eq("t1_bg", LW'(dma_bg), LW'(1));
    check_eq("t1_state", LW'(dbg_state), LW'(ST_DMA));
    check_eq("t1_grant_cnt", LW'(num_dma_grant), LW'(1));
    check_eq("t1_stall", LW'(cpu_stall), LW'(1));
    dma_write_start(1);
    settle();
    check_eq("t1_mem_write", LW'(mem_writeM), LW'(1));
    check_eq("t1_mem_read", LW'(mem_readM), LW'(0));
    cyc();
    mem_doneM = 1;
    settle();
    check_eq("t1_dma_done", LW'(dma_doneM), LW'(1));
    cyc();
    mem_doneM = 0; dma_writeM = 0;
    dma_br = 0;
    settle();
    check_eq("t1_bg_held", LW'(dma_bg), LW'(1));
    cyc();
    check_eq("t1_bg_drop", LW'(dma_bg), LW'(0));
    check_eq("t1_release", LW'(dbg_state), LW'(ST_REL));
    check_eq("t1_rel_stall", LW'(cpu_stall), LW'(1));
    cyc();
    check_eq("t1_idle", LW'(dbg_state), LW'(ST_IDLE));
    check_eq("t1_idle_stall", LW'(cpu_stall), LW'(0));

    // Drain: CPU read in flight when dma_br rises.
    do_reset();
    cpu_readM = 1;
    cpu_address = WS'($urandom_range(0, 16'hffff));
    settle();
    check_eq("t2_mem_read", LW'(mem_readM), LW'(1));
    check_eq("t2_mem_addr", LW'(mem_address), LW'(cpu_address));
    cyc();
    check_eq("t2_busy", LW'(dbg_state), LW'(ST_BUSY));
    dma_br = 1;
    cyc();
    check_eq("t2_drain", LW'(dbg_state), LW'(ST_DRAIN));
    check_eq("t2_bg_wait", LW'(dma_bg), LW'(0));
    cyc();
    mem_read_ready();
    settle();
    check_eq("t2_cpu_ready", LW'(cpu_readyM), LW'(1));
    check_eq("t2_bg_before", LW'(dma_bg), LW'(0));
    cyc();
    mem_readyM = 0; cpu_readM = 0;
    check_eq("t2_bg_after", LW'(dma_bg), LW'(1));
    check_eq("t2_grant_cnt", LW'(num_dma_grant), LW'(1));
    mem_readyM = 1;
    settle();
    check_eq("t2_ready_gated", LW'(cpu_readyM), LW'(0));
    mem_readyM = 0;
    dma_br = 0;
    cyc();
    cyc();
    check_eq("t2_idle", LW'(dbg_state), LW'(ST_IDLE));

    // Tie: CPU write and dma_br rise together.
    do_reset();
    cpu_writeM = 1;
    cpu_address = WS'($urandom_range(0, 16'hffff));
    cpu_wdata = {$urandom, $urandom};
    dma_br = 1;
    settle();
    check_eq("t3_mem_write", LW'(mem_writeM), LW'(1));
    check_eq("t3_mem_wdata", mem_wdata, cpu_wdata);
    cyc();
    check_eq("t3_drain", LW'(dbg_state), LW'(ST_DRAIN));
    check_eq("t3_bg_wait", LW'(dma_bg), LW'(0));
    cyc();
    mem_doneM = 1;
    settle();
    check_eq("t3_cpu_done", LW'(cpu_doneM), LW'(1));
    check_eq("t3_dma_done_gated", LW'(dma_doneM), LW'(0));
    cyc();
    mem_doneM = 0; cpu_writeM = 0;
    check_eq("t3_bg", LW'(dma_bg), LW'(1));
    check_eq("t3_grant_cnt", LW'(num_dma_grant), LW'(1));
    dma_br = 0;
    cyc();
    cyc();

    // In-flight DMA write holds the grant after dma_br drops.
    do_reset();
    exp_stall = 0;
    dma_br = 1;
    cyc();
    cpu_readM = 1;
    cpu_address = WS'($urandom_range(0, 16'hffff));
    dma_write_start(1);
    settle();
    check_eq("t4_stall", LW'(cpu_stall), LW'(1));
    check_eq("t4_mem_read_blocked", LW'(mem_readM), LW'(0));
    exp_stall++;
    cyc();
    dma_br = 0;
    exp_stall++;
    cyc();
    check_eq("t4_hold1", LW'(dma_bg), LW'(1));
    exp_stall++;
    cyc();
    check_eq("t4_hold2", LW'(dma_bg), LW'(1));
    mem_doneM = 1;
    settle();
    check_eq("t4_dma_done", LW'(dma_doneM), LW'(1));
    exp_stall++;
    cyc();
    mem_doneM = 0; dma_writeM = 0;
    check_eq("t4_bg_drop", LW'(dma_bg), LW'(0));
    check_eq("t4_release", LW'(dbg_state), LW'(ST_REL));
    check_eq("t4_rel_mem_read", LW'(mem_readM), LW'(0));
    exp_stall++;
    cyc();
    check_eq("t4_idle_read", LW'(mem_readM), LW'(1));
    check_eq("t4_stall_cnt", LW'(num_cpu_stall), LW'(exp_stall));
    cyc();
    mem_read_ready();
    settle();
    check_eq("t4_cpu_ready", LW'(cpu_readyM), LW'(1));
    cyc();
    mem_readyM = 0; cpu_readM = 0;
    check_eq("t4_end_idle", LW'(dbg_state), LW'(ST_IDLE));
    check_eq("t4_stall_cnt_end", LW'(num_cpu_stall), LW'(exp_stall));

    // Long DMA hold with a CPU read pending.
    do_reset();
    exp_stall = 0;
    dma_br = 1;
    cyc();
    cpu_readM = 1;
    cpu_address = WS'($urandom_range(0, 16'hffff));
`ifdef ARB_STEAL_LIMIT_EN
    for (int i = 1; i <= 12; i++) begin
      check_eq("t5_hold", LW'(dma_bg), LW'(1));
      exp_stall++;
      cyc();
    end
    check_eq("t5_revoke", LW'(dma_bg), LW'(0));
    check_eq("t5_revoke_state", LW'(dbg_state), LW'(ST_REL));
    exp_stall++;
    cyc();
    check_eq("t5_idle_read", LW'(mem_readM), LW'(1));
    check_eq("t5_stall_cnt", LW'(num_cpu_stall), LW'(exp_stall));
    cyc();
    check_eq("t5_drain", LW'(dbg_state), LW'(ST_DRAIN));
    mem_read_ready();
    settle();
    check_eq("t5_cpu_ready", LW'(cpu_readyM), LW'(1));
    cyc();
    mem_readyM = 0; cpu_readM = 0;
    check_eq("t5_regrant", LW'(dma_bg), LW'(1));
    check_eq("t5_grant_cnt", LW'(num_dma_grant), LW'(2));
    dma_br = 0;
    cyc();
    cyc();
`else
    for (int i = 1; i <= 20; i++) begin
      check_eq("t5_hold", LW'(dma_bg), LW'(1));
      exp_stall++;
      cyc();
    end
    dma_br = 0;
    settle();
    check_eq("t5_still_dma", LW'(dbg_state), LW'(ST_DMA));
    exp_stall++;
    cyc();
    check_eq("t5_release", LW'(dbg_state), LW'(ST_REL));
    exp_stall++;
    cyc();
    check_eq("t5_stall_cnt", LW'(num_cpu_stall), LW'(exp_stall));
    check_eq("t5_grant_cnt", LW'(num_dma_grant), LW'(1));
    cyc();
    mem_read_ready();
    settle();
    check_eq("t5_cpu_ready", LW'(cpu_readyM), LW'(1));
    cyc();
    mem_readyM = 0; cpu_readM = 0;
`endif

    // Reset while the DMA is mid-write.
    do_reset();
    dma_br = 1;
    cyc();
    dma_write_start(0);
    settle();
    check_eq("t6_mem_write", LW'(mem_writeM), LW'(1));
    cyc();
    reset_n = 0;
    settle();
    check_eq("t6_wr_forced", LW'(mem_writeM), LW'(0));
    cyc();
    check_eq("t6_bg", LW'(dma_bg), LW'(0));
    check_eq("t6_state", LW'(dbg_state), LW'(ST_IDLE));
    check_eq("t6_grant_cnt", LW'(num_dma_grant), LW'(0));
    check_eq("t6_stall_cnt", LW'(num_cpu_stall), LW'(0));
    check_eq("t6_stall", LW'(cpu_stall), LW'(0));
    reset_n = 1;
    dma_br = 0; dma_writeM = 0;
    cyc();
    check_eq("t6_idle_after", LW'(dbg_state), LW'(ST_IDLE));

    check_eq("rd_sb_drained", LW'(rd_exp_q.size()), LW'(0));
    check_eq("wr_sb_drained", LW'(wr_exp_q.size()), LW'(0));
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
